ofdm_cp_remover: RTL and testbench

- Stage directly downstream of the Schmidl-Cox detector output stream, feeding the FFT.
- Takes the detector's time-aligned OFDM frame (one AXI-Stream frame per detected OFDM packet, tlast on the final sample).
- Drops a configurable number of leading preamble symbols, strips the cyclic prefix of every remaining symbol, and emits FFT_SIZE-sample symbol bodies, each as its own tlast-delimited packet.
- Flags end of frame and counts truncated frames.

---
 rtl/ofdm_cp_remover.sv | 135 +++++++++++++
 tb/tb_ofdm_cp_remover.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_remover.sv
// ofdm_cp_remover: drops preamble symbols and cyclic prefixes, emits FFT-sized symbol bodies
module ofdm_cp_remover #(
    parameter int FFT_SIZE = 5120,
    parameter int CP_SIZE  = 640,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        cfg_skip_symbols,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_teob,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [31:0]       symbols_out,
    output logic [15:0]       truncated_frames
);
    localparam int SYM = CP_SIZE + FFT_SIZE;
    localparam int CW  = $clog2(SYM);
    localparam logic [CW-1:0] CP_LAST  = CW'(CP_SIZE - 1);
    localparam logic [CW-1:0] FFT_LAST = CW'(FFT_SIZE - 1);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYM - 1);

    typedef enum logic [1:0] {IDLE, SKIP, CP, BODY} state_t;

    state_t              state, state_n, eff;
    logic [CW-1:0]       sample_cnt, sample_cnt_n, cnt;
    logic [7:0]          sym_cnt, sym_cnt_n, sym, skip, skip_n, sk;
    logic [DATA_W-1:0]   o_tdata_n;
    logic                o_tlast_n, o_teob_n, o_tvalid_n, o_sym, o_sym_n;
    logic                in_beat, out_beat, trunc_inc;

    assign i_tready = (state == BODY) ? (!o_tvalid | o_tready) : 1'b1;
    assign in_beat  = i_tvalid & i_tready;
    assign out_beat = o_tvalid & o_tready;

    // Next-state, counters and output register contents; an IDLE beat is processed as sample 0 of its first symbol
    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        sym_cnt_n    = sym_cnt;
        skip_n       = skip;
        trunc_inc    = 1'b0;
        o_tvalid_n   = o_tvalid & !o_tready;
        o_tlast_n    = out_beat ? 1'b0 : o_tlast;
        o_teob_n     = out_beat ? 1'b0 : o_teob;
        o_sym_n      = out_beat ? 1'b0 : o_sym;
        o_tdata_n    = o_tdata;
        eff          = (state == IDLE) ? ((cfg_skip_symbols != 8'd0) ? SKIP : CP) : state;
        cnt          = (state == IDLE) ? '0 : sample_cnt;
        sym          = (state == IDLE) ? 8'd0 : sym_cnt;
        sk           = (state == IDLE) ? cfg_skip_symbols : skip;
        if (in_beat) begin
            state_n      = eff;
            sample_cnt_n = cnt + CW'(1);
            sym_cnt_n    = sym;
            skip_n       = sk;
            case (eff)
                SKIP: begin
                    if (i_tlast) begin
                        state_n      = IDLE;
                        sample_cnt_n = '0;
                        trunc_inc    = (cnt != SYM_LAST);
                    end else if (cnt == SYM_LAST) begin
                        sample_cnt_n = '0;
                        sym_cnt_n    = sym + 8'd1;
                        state_n      = (sym + 8'd1 == sk) ? CP : SKIP;
                    end
                end
                CP: begin
                    if (i_tlast) begin
                        state_n      = IDLE;
                        sample_cnt_n = '0;
                        trunc_inc    = 1'b1;
                    end else if (cnt == CP_LAST) begin
                        state_n      = BODY;
                        sample_cnt_n = '0;
                    end
                end
                BODY: begin
                    o_tvalid_n = 1'b1;
                    o_tdata_n  = i_tdata;
                    o_tlast_n  = (cnt == FFT_LAST) | i_tlast;
                    o_teob_n   = i_tlast;
                    o_sym_n    = (cnt == FFT_LAST);
                    if (i_tlast) begin
                        state_n      = IDLE;
                        sample_cnt_n = '0;
                        trunc_inc    = (cnt != FFT_LAST);
                    end else if (cnt == FFT_LAST) begin
                        state_n      = CP;
                        sample_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, output register and statistics counters
    always_ff @(posedge clk) begin
        if (reset | clear) begin
            state            <= IDLE;
            sample_cnt       <= '0;
            sym_cnt          <= 8'd0;
            skip             <= 8'd0;
            o_tdata          <= '0;
            o_tlast          <= 1'b0;
            o_teob           <= 1'b0;
            o_tvalid         <= 1'b0;
            o_sym            <= 1'b0;
            symbols_out      <= 32'd0;
            truncated_frames <= 16'd0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            sym_cnt    <= sym_cnt_n;
            skip       <= skip_n;
            o_tdata    <= o_tdata_n;
            o_tlast    <= o_tlast_n;
            o_teob     <= o_teob_n;
            o_tvalid   <= o_tvalid_n;
            o_sym      <= o_sym_n;
            if (out_beat & o_sym)
                symbols_out <= symbols_out + 32'd1;
            if (trunc_inc & (truncated_frames != 16'hFFFF))
                truncated_frames <= truncated_frames + 16'd1;
        end
    end
endmodule

// File: tb/tb_ofdm_cp_remover.sv
// tb_ofdm_cp_remover: scoreboard bench for the CP remover with FFT_SIZE=8, CP_SIZE=2
module tb_ofdm_cp_remover;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  cfg_skip_symbols = 8'd0;
    logic [31:0] i_tdata = 32'd0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_teob, o_tvalid;
    logic        o_tready = 1'b1;
    logic [31:0] symbols_out;
    logic [15:0] truncated_frames;

    int passed = 0;
    int total = 0;
    bit bp_en = 1'b0;
    logic [33:0] exp_q[$];

    ofdm_cp_remover #(.FFT_SIZE(8), .CP_SIZE(2), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .clear(clear), .cfg_skip_symbols(cfg_skip_symbols),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_teob(o_teob), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .symbols_out(symbols_out), .truncated_frames(truncated_frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // downstream ready: 1,0,0,1 pattern when backpressure is enabled
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            o_tready = bp_en ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            k++;
        end
    end

    // monitor: pop and compare every accepted output beat
    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) chk("unexpected_output", {o_tdata, o_tlast, o_teob}, 34'h0);
            else chk("out_beat", {o_tdata, o_tlast, o_teob}, exp_q.pop_front());
        end
    end

    task automatic expect_sym(input int lo, input int hi, input bit eob);
        for (int v = lo; v <= hi; v++)
            exp_q.push_back({32'(v), v == hi, eob && (v == hi)});
    endtask

    task automatic send_frame(input int n, input logic [7:0] skip, input logic [7:0] cfg_after,
                              input bit chk_cp, input bit last_flag);
        for (int i = 0; i < n; i++) begin
            int  w = 0;
            bit  ok;
            cfg_skip_symbols = (i == 0) ? skip : cfg_after;
            i_tdata  = 32'(i);
            i_tlast  = last_flag && (i == n - 1);
            i_tvalid = 1'b1;
            forever begin
                @(negedge clk);
                ok = i_tready;
                if (chk_cp && w == 0 && (i % 10) < 2) chk("cp_ready", 64'(ok), 64'd1);
                @(posedge clk);
                #1;
                if (ok) break;
                w++;
                if (w > 100) begin
                    chk("input_stall", 64'(w), 64'd0);
                    break;
                end
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain_and_check(input int so, input int tf);
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("symbols_out", 64'(symbols_out), 64'(so));
        chk("truncated_frames", 64'(truncated_frames), 64'(tf));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_o_tlast", 64'(o_tlast), 64'd0);
        chk("rst_o_teob", 64'(o_teob), 64'd0);
        chk("rst_o_tdata", 64'(o_tdata), 64'd0);
        chk("rst_symbols_out", 64'(symbols_out), 64'd0);
        chk("rst_truncated", 64'(truncated_frames), 64'd0);
        chk("rst_i_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;

        // exact two-symbol frame, no skip
        expect_sym(2, 9, 0);
        expect_sym(12, 19, 1);
        send_frame(20, 8'd0, 8'd0, 0, 1);
        drain_and_check(2, 0);
        pulse_clear();

        // one preamble symbol skipped; cfg change mid-frame ignored
        expect_sym(12, 19, 0);
        expect_sym(22, 29, 1);
        send_frame(30, 8'd1, 8'd3, 0, 1);
        drain_and_check(2, 0);
        pulse_clear();

        // frame truncated mid-body
        expect_sym(2, 9, 0);
        expect_sym(12, 14, 1);
        send_frame(15, 8'd0, 8'd0, 0, 1);
        drain_and_check(1, 1);
        pulse_clear();

        // frame ends inside CP
        expect_sym(2, 9, 0);
        send_frame(12, 8'd0, 8'd0, 0, 1);
        drain_and_check(1, 1);
        pulse_clear();

        // frame ends exactly on a skipped symbol boundary
        send_frame(10, 8'd1, 8'd1, 0, 1);
        drain_and_check(0, 0);
        pulse_clear();

        // backpressure over the exact two-symbol frame
        bp_en = 1'b1;
        expect_sym(2, 9, 0);
        expect_sym(12, 19, 1);
        send_frame(20, 8'd0, 8'd0, 1, 1);
        drain_and_check(2, 0);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pulse_clear();

        // reset in the body of symbol 1, then a fresh frame
        expect_sym(2, 9, 0);
        exp_q.push_back({32'd12, 1'b0, 1'b0});
        exp_q.push_back({32'd13, 1'b0, 1'b0});
        send_frame(14, 8'd0, 8'd0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("post_reset_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        expect_sym(2, 9, 1);
        send_frame(10, 8'd0, 8'd0, 0, 1);
        drain_and_check(1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end
endmodule
